// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimator: register-width rule and the
// default input sample type.
package cic_pkg;

    localparam int CIC_WIDTH_IN = 8;

    typedef logic signed [CIC_WIDTH_IN-1:0] cic_sample_t;

    // Bit growth of N integrator/comb pairs is N*log2(R*M) over the input.
    function automatic int cic_reg_width(input int width_in, input int n_stages,
                                         input int r, input int m);
        return width_in + n_stages * $clog2(r * m);
    endfunction

endpackage

// File: rtl/cic_stage.sv
// One integrator (sample rate) paired with one comb (decimated rate).
// Both use modulo arithmetic at the full register width.
module cic_stage #(
    parameter int WIDTH = 17,
    parameter int M     = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic                    tick,
    input  logic signed [WIDTH-1:0] integ_in,
    output logic signed [WIDTH-1:0] integ_out,
    input  logic signed [WIDTH-1:0] comb_in,
    output logic signed [WIDTH-1:0] comb_out
);

    logic signed [WIDTH-1:0] integ_q;
    logic signed [WIDTH-1:0] dly_q [M];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the chain behaves as a true pipeline.
    // NOTE: the comb delay line is small and must start from zero history, so
    // it is reset like any other register rather than left as RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            integ_q <= '0;
            for (int i = 0; i < M; i++) dly_q[i] <= '0;
        end else if (clear) begin
            integ_q <= '0;
            for (int i = 0; i < M; i++) dly_q[i] <= '0;
        end else begin
            if (in_valid) integ_q <= integ_q + integ_in;
            if (tick) begin
                dly_q[0] <= comb_in;
                for (int i = 1; i < M; i++) dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign integ_out = integ_q;
    assign comb_out  = comb_in - dly_q[M-1];

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: pipelined integrators, tick-gated combs, truncated
// registered output with fixed two-cycle latency from the R-th sample.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int WIDTH_IN  = 8,
    parameter int N_STAGES  = 3,
    parameter int R         = 8,
    parameter int M         = 1,
    parameter int WIDTH_OUT = 17
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [WIDTH_IN-1:0]  x_in,
    output logic                        out_valid,
    output logic signed [WIDTH_OUT-1:0] y_out
);

    localparam int WIDTH_REG = cic_reg_width(WIDTH_IN, N_STAGES, R, M);
    localparam int PHASE_W   = $clog2(R);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(R - 1);

    if (WIDTH_IN < 1) begin : g_bad_width_in
        $error("cic_decimator: WIDTH_IN must be at least 1");
    end
    if (N_STAGES < 1) begin : g_bad_stages
        $error("cic_decimator: N_STAGES must be at least 1");
    end
    if (R < 2 || R > 64) begin : g_bad_r
        $error("cic_decimator: R must be in 2..64");
    end
    if (M != 1 && M != 2) begin : g_bad_m
        $error("cic_decimator: M must be 1 or 2");
    end
    if (WIDTH_OUT < 1 || WIDTH_OUT > WIDTH_REG) begin : g_bad_width_out
        $error("cic_decimator: WIDTH_OUT must be in 1..WIDTH_REG");
    end

    logic signed [WIDTH_REG-1:0] x_ext;
    logic signed [WIDTH_REG-1:0] integ [N_STAGES];
    logic signed [WIDTH_REG-1:0] comb  [N_STAGES];
    logic [PHASE_W-1:0]          phase_q;
    logic                        tick_q;

    assign x_ext = {{(WIDTH_REG - WIDTH_IN){x_in[WIDTH_IN-1]}}, x_in};

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        logic signed [WIDTH_REG-1:0] stage_integ_in;
        logic signed [WIDTH_REG-1:0] stage_comb_in;

        // The first comb reads the last integrator; later stages chain.
        if (k == 0) begin : g_first
            assign stage_integ_in = x_ext;
            assign stage_comb_in  = integ[N_STAGES-1];
        end else begin : g_next
            assign stage_integ_in = integ[k-1];
            assign stage_comb_in  = comb[k-1];
        end

        cic_stage #(
            .WIDTH (WIDTH_REG),
            .M     (M)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .clear     (clear),
            .in_valid  (in_valid),
            .tick      (tick_q),
            .integ_in  (stage_integ_in),
            .integ_out (integ[k]),
            .comb_in   (stage_comb_in),
            .comb_out  (comb[k])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= '0;
            tick_q    <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
        end else if (clear) begin
            phase_q   <= '0;
            tick_q    <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
        end else begin
            tick_q    <= in_valid && (phase_q == PHASE_LAST);
            out_valid <= tick_q;
            if (in_valid) phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            if (tick_q) y_out <= comb[N_STAGES-1][WIDTH_REG-1 -: WIDTH_OUT];
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench: a direct-form FIR model predicts each decimated output
// and its arrival cycle; monitors pop and compare when out_valid pulses.
module tb_cic_decimator;
    import cic_pkg::*;

    localparam int R_DEF   = 8;
    localparam int N_DEF   = 3;
    localparam int PIPE    = N_DEF - 1;
    localparam int R_IMP   = 4;

    typedef struct {
        int id;
        int val;
        int due;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_valid_b;
    cic_sample_t x_in;
    cic_sample_t x_b;
    logic               out_valid;
    logic signed [16:0] y_out;
    logic               out_valid_b;
    logic signed [9:0]  y_b;

    cic_decimator dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .out_valid (out_valid),
        .y_out     (y_out)
    );

    cic_decimator #(
        .WIDTH_IN  (8),
        .N_STAGES  (1),
        .R         (R_IMP),
        .M         (1),
        .WIDTH_OUT (10)
    ) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid_b),
        .x_in      (x_b),
        .out_valid (out_valid_b),
        .y_out     (y_b)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic clr_q = 1'b0;
    exp_t sb[$];
    int   hist[$];
    int   h[];
    int   h_tmp[];
    int   phase   = 0;
    int   phase_b = 0;
    int   grp_b   = 0;
    logic signed [31:0] last_y [2];

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        clr_q <= clear;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap17(input int v);
        logic signed [16:0] w;
        w = v[16:0];
        return int'(w);
    endfunction

    // Output after accepted sample n: CIC impulse response convolved with the
    // input history, delayed by the integrator pipeline.
    function automatic int model(input int n);
        int acc = 0;
        for (int j = 0; j < h.size(); j++)
            if (n - PIPE - j >= 0) acc += h[j] * hist[n - PIPE - j];
        return wrap17(acc);
    endfunction

    task automatic mon(input int id, input logic ov, input logic signed [31:0] y);
        int idx;
        if (!reset_n || clr_q) begin
            check($sformatf("zero_valid%0d", id), 32'(ov), 0);
            check($sformatf("zero_y%0d", id), y, 0);
            last_y[id] = 0;
        end else if (ov === 1'b1) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].id == id) idx = i;
            if (idx < 0) begin
                check($sformatf("spurious_pulse%0d", id), 32'(ov), 0);
            end else begin
                check($sformatf("value%0d", id), y, sb[idx].val);
                check($sformatf("latency%0d", id), cyc, sb[idx].due);
                last_y[id] = sb[idx].val;
                sb.delete(idx);
            end
        end else begin
            check($sformatf("valid_low%0d", id), 32'(ov), 0);
            check($sformatf("hold%0d", id), y, last_y[id]);
        end
    endtask

    always @(negedge clock) begin
        mon(0, out_valid, 32'(y_out));
        mon(1, out_valid_b, 32'(y_b));
    end

    task automatic drive(input logic v, input int x, input logic vb, input int xb);
        @(posedge clock);
        #1;
        in_valid   = v;
        x_in       = cic_sample_t'(x);
        in_valid_b = vb;
        x_b        = cic_sample_t'(xb);
        if (v) begin
            hist.push_back(x);
            phase++;
            if (phase == R_DEF) begin
                phase = 0;
                sb.push_back('{id: 0, val: model(hist.size() - 1), due: cyc + 2});
            end
        end
        if (vb) begin
            phase_b++;
            if (phase_b == R_IMP) begin
                phase_b = 0;
                sb.push_back('{id: 1, val: (grp_b == 0) ? 1 : 0, due: cyc + 2});
                grp_b++;
            end
        end
    endtask

    task automatic reset_model();
        hist.delete();
        sb.delete();
        phase   = 0;
        phase_b = 0;
        grp_b   = 0;
    endtask

    task automatic do_clear();
        @(posedge clock);
        #1;
        clear      = 1'b1;
        in_valid   = 1'b1;
        x_in       = 1;
        in_valid_b = 1'b1;
        x_b        = 1;
        reset_model();
        @(posedge clock);
        #1;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            drive(1'b0, 0, 1'b0, 0);
            n++;
        end
        repeat (2) drive(1'b0, 0, 1'b0, 0);
        check(tag, sb.size(), 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        x_in       = '0;
        x_b        = '0;
        last_y[0]  = 0;
        last_y[1]  = 0;

        h = new[1];
        h[0] = 1;
        repeat (N_DEF) begin
            h_tmp = new[h.size() + R_DEF - 1];
            foreach (h[i]) for (int j = 0; j < R_DEF; j++) h_tmp[i + j] += h[i];
            h = h_tmp;
        end

        repeat (3) @(posedge clock);
        #1;
        check("reset_y", 32'(y_out), 0);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_y_b", 32'(y_b), 0);
        #2 reset_n = 1'b1;

        // DC +1 on the default instance, unit impulse on the N=1/R=4 instance.
        for (int i = 0; i < 48; i++) drive(1'b1, 1, i < 16, (i == 0) ? 1 : 0);
        drain("drain_dc");
        check("dc_steady", 32'(y_out), 512);
        check("impulse_tail", 32'(y_b), 0);

        // Full-scale negative input.
        for (int i = 0; i < 64; i++) drive(1'b1, -128, 1'b0, 0);
        drain("drain_neg");
        check("neg_steady", 32'(y_out), -65536);

        // Gapped input after a clear: one valid cycle in three.
        do_clear();
        for (int i = 0; i < 144; i++) drive((i % 3) == 0, 1, 1'b0, 0);
        drain("drain_gap");
        check("gap_steady", 32'(y_out), 512);

        // Clear (with in_valid high) after 5 of 8 samples.
        for (int i = 0; i < 5; i++) drive(1'b1, 1, 1'b0, 0);
        do_clear();
        for (int i = 0; i < 8; i++) drive(1'b1, 1, 1'b0, 0);
        drain("drain_clear");
        check("clear_first", 32'(y_out), 56);

        // Asynchronous reset mid-group.
        for (int i = 0; i < 3; i++) drive(1'b1, 1, 1'b0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_y", 32'(y_out), 0);
        check("async_valid", 32'(out_valid), 0);
        reset_model();
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 1, 1'b0, 0);
        drain("drain_reset");
        check("reset_second", 32'(y_out), 392);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
